// File: rtl/lock_pkg.sv
// lock_pkg: shared state encoding, default parameters and timer sizing for the lock controller.
package lock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    OPEN    = 2'b10,
    LOCKOUT = 2'b11
  } lock_state_t;

  localparam int unsigned LOCK_WINDOW_DEF    = 16;
  localparam int unsigned LOCK_HOLD_DEF      = 8;
  localparam int unsigned LOCK_MAX_FAILS_DEF = 3;
  localparam int unsigned LOCK_LOCKOUT_DEF   = 32;

  // Width able to hold max(a, b, c) - 1, never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter that saturates at zero and flags when it is there.
module lock_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority over counting; counting stops at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lock_controller.sv
// lock_controller: timed entry window, unlock hold and failure lockout behind the sequence detector.
// Optional feature: define LOCK_ALARM_EN to drive alarm during lockout; otherwise alarm is tied low.
module lock_controller
  import lock_pkg::*;
#(
  parameter int unsigned WINDOW    = LOCK_WINDOW_DEF,
  parameter int unsigned HOLD      = LOCK_HOLD_DEF,
  parameter int unsigned MAX_FAILS = LOCK_MAX_FAILS_DEF,
  parameter int unsigned LOCKOUT   = LOCK_LOCKOUT_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               match,
  output logic                               unlock,
  output logic                               busy,
  output logic                               alarm,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_cnt
);

  localparam int unsigned TW = timer_width(WINDOW, HOLD, LOCKOUT);
  localparam int unsigned FW = $clog2(MAX_FAILS + 1);

  lock_state_t   state;
  lock_state_t   state_nxt;
  logic [FW-1:0] fail_nxt;
  logic [FW-1:0] fail_inc;
  logic          tmr_load;
  logic [TW-1:0] tmr_load_val;
  logic          tmr_en;
  logic          tmr_zero;

  // Single timer shared by the window, hold and lockout phases.
  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  assign fail_inc = FW'(fail_cnt + FW'(1));

  // Next-state, failure-count and timer-control decode.
  always_comb begin
    state_nxt    = state;
    fail_nxt     = fail_cnt;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;
    case (state)
      lock_pkg::IDLE: begin
        if (start) begin
          state_nxt    = lock_pkg::ARMED;
          tmr_load     = 1'b1;
          tmr_load_val = TW'(WINDOW - 1);
        end
      end
      lock_pkg::ARMED: begin
        // A match in the final window cycle still wins over the timeout.
        if (match) begin
          state_nxt    = lock_pkg::OPEN;
          tmr_load     = 1'b1;
          tmr_load_val = TW'(HOLD - 1);
          fail_nxt     = '0;
        end else if (tmr_zero) begin
          fail_nxt = fail_inc;
          if (fail_inc == FW'(MAX_FAILS)) begin
            state_nxt    = lock_pkg::LOCKOUT;
            tmr_load     = 1'b1;
            tmr_load_val = TW'(LOCKOUT - 1);
          end else begin
            state_nxt = lock_pkg::IDLE;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      lock_pkg::OPEN: begin
        if (tmr_zero) begin
          state_nxt = lock_pkg::IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      lock_pkg::LOCKOUT: begin
        if (tmr_zero) begin
          state_nxt = lock_pkg::IDLE;
          fail_nxt  = '0;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: begin
        state_nxt = lock_pkg::IDLE;
      end
    endcase
  end

  // State, failure count and Moore outputs registered together so outputs track state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= lock_pkg::IDLE;
      fail_cnt <= '0;
      unlock   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      fail_cnt <= fail_nxt;
      unlock   <= (state_nxt == lock_pkg::OPEN);
      busy     <= (state_nxt != lock_pkg::IDLE);
    end
  end

`ifdef LOCK_ALARM_EN
  // Alarm follows the lockout state.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm <= 1'b0;
    end else begin
      alarm <= (state_nxt == lock_pkg::LOCKOUT);
    end
  end
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_lock_controller.sv
// tb_lock_controller: directed vector table plus hand-written corner sequences for lock_controller.
module tb_lock_controller;

`ifdef LOCK_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic       match;
  logic       unlock;
  logic       busy;
  logic       alarm;
  logic [1:0] fail_cnt;

  int checks = 0;
  int errors = 0;

  lock_controller #(
    .WINDOW    (16),
    .HOLD      (8),
    .MAX_FAILS (3),
    .LOCKOUT   (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .match    (match),
    .unlock   (unlock),
    .busy     (busy),
    .alarm    (alarm),
    .fail_cnt (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are applied on the first edge of a record only; expectations hold for all n edges.
  typedef struct {
    logic       r;
    logic       s;
    logic       m;
    int         n;
    logic       eu;
    logic       eb;
    logic       lk;
    logic [1:0] ef;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string nm, input logic eu, input logic eb,
                       input logic ea, input logic [1:0] ef);
    checks++;
    if (unlock !== eu || busy !== eb || alarm !== ea || fail_cnt !== ef) begin
      errors++;
      $display("FAIL %s: got unlock=%b busy=%b alarm=%b fail_cnt=%0d, want unlock=%b busy=%b alarm=%b fail_cnt=%0d",
               nm, unlock, busy, alarm, fail_cnt, eu, eb, ea, ef);
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic m);
    rst   = r;
    start = s;
    match = m;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    match = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    match = 1'b0;

    //        r     s     m     n   unl   bsy   lk    fail
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b0, 2'd0}; // reset
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 3,  1'b0, 1'b1, 1'b0, 2'd0}; // ARMED cycles 1..3
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8,  1'b1, 1'b1, 1'b0, 2'd0}; // match -> OPEN for 8
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b0, 2'd0}; // back to IDLE
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b0, 2'd0}; // full window, no match
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 3,  1'b0, 1'b0, 1'b0, 2'd1}; // first failure
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b0, 2'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b0, 2'd2}; // second failure
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 5,  1'b0, 1'b1, 1'b1, 2'd3}; // lockout 1..5
    vecs[10] = '{1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b1, 1'b1, 2'd3}; // start ignored, 6..15
    vecs[11] = '{1'b0, 1'b0, 1'b1, 17, 1'b0, 1'b1, 1'b1, 2'd3}; // match ignored, 16..32
    vecs[12] = '{1'b0, 1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b0, 2'd0}; // exit, nothing queued

    for (int i = 0; i < 13; i++) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        if (c == 0) tick(vecs[i].r, vecs[i].s, vecs[i].m);
        else        tick(1'b0, 1'b0, 1'b0);
        check($sformatf("vec%0d.c%0d", i, c), vecs[i].eu, vecs[i].eb,
              vecs[i].lk & ALARM_ON, vecs[i].ef);
      end
    end

    // match alone in IDLE is ignored
    tick(1'b0, 1'b0, 1'b1);
    check("idle_match", 1'b0, 1'b0, 1'b0, 2'd0);

    // start and match together in IDLE: window opens, match not credited
    tick(1'b0, 1'b1, 1'b1);
    check("sm_armed1", 1'b0, 1'b1, 1'b0, 2'd0);
    for (int k = 2; k <= 16; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      check($sformatf("sm_armed%0d", k), 1'b0, 1'b1, 1'b0, 2'd0);
    end
    tick(1'b0, 1'b0, 1'b0);
    check("sm_timeout", 1'b0, 1'b0, 1'b0, 2'd1);

    // match on the 16th (last) ARMED cycle wins over the timeout and clears fail_cnt
    tick(1'b0, 1'b1, 1'b0);
    check("last_armed1", 1'b0, 1'b1, 1'b0, 2'd1);
    for (int k = 2; k <= 16; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      check($sformatf("last_armed%0d", k), 1'b0, 1'b1, 1'b0, 2'd1);
    end
    tick(1'b0, 1'b0, 1'b1);
    check("last_open1", 1'b1, 1'b1, 1'b0, 2'd0);
    for (int k = 2; k <= 8; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      check($sformatf("last_open%0d", k), 1'b1, 1'b1, 1'b0, 2'd0);
    end
    tick(1'b0, 1'b0, 1'b0);
    check("open_exit", 1'b0, 1'b0, 1'b0, 2'd0);

    // start in the first IDLE cycle after OPEN is accepted; then rst on 4th OPEN cycle
    tick(1'b0, 1'b1, 1'b0);
    check("b2b_start", 1'b0, 1'b1, 1'b0, 2'd0);
    tick(1'b0, 1'b0, 1'b1);
    check("rst_open1", 1'b1, 1'b1, 1'b0, 2'd0);
    for (int k = 2; k <= 4; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      check($sformatf("rst_open%0d", k), 1'b1, 1'b1, 1'b0, 2'd0);
    end
    tick(1'b1, 1'b0, 1'b0);
    check("rst_in_open", 1'b0, 1'b0, 1'b0, 2'd0);

    // fresh 16-cycle window after reset
    tick(1'b0, 1'b1, 1'b0);
    check("fresh1", 1'b0, 1'b1, 1'b0, 2'd0);
    for (int k = 2; k <= 16; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      check($sformatf("fresh%0d", k), 1'b0, 1'b1, 1'b0, 2'd0);
    end
    tick(1'b0, 1'b0, 1'b0);
    check("fresh_timeout", 1'b0, 1'b0, 1'b0, 2'd1);

    // rst mid-ARMED clears the accumulated failure count
    tick(1'b0, 1'b1, 1'b0);
    check("rst_armed_pre", 1'b0, 1'b1, 1'b0, 2'd1);
    tick(1'b1, 1'b0, 1'b0);
    check("rst_in_armed", 1'b0, 1'b0, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lock_controller.md
# lock_controller

Access-control stage directly downstream of the serial sequence detector in the digital lock. It opens a timed entry window on `start` and watches the detector's one-cycle `match` pulse. A hit unlocks the door for a fixed hold time. A window that closes without a hit counts as a failed attempt, and repeated failures force a timed lockout with an optional alarm.

## Interface
Parameters:
- `WINDOW`, 16: entry-window length in cycles, ≥1.
- `HOLD`, 8: unlock duration in cycles, ≥1.
- `MAX_FAILS`, 3: consecutive failed windows that trigger lockout, ≥1.
- `LOCKOUT`, 32: lockout duration in cycles, ≥1.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request that opens an entry window.
- `match` in 1: detector hit pulse (the upstream `z`).
- `unlock` out 1: door release.
- `busy` out 1: high in any state other than IDLE.
- `alarm` out 1: lockout alarm (see Configuration).
- `fail_cnt` out `$clog2(MAX_FAILS+1)`: consecutive failed windows.

## Operation
- States: IDLE, ARMED, OPEN, LOCKOUT. One shared down-counter `timer` is wide enough for max(WINDOW, HOLD, LOCKOUT)−1.
- **IDLE**
  - `start`=1 → ARMED, `timer`←WINDOW−1.
  - `match` is ignored.
- **ARMED**
  - `match`=1 → OPEN, `timer`←HOLD−1, `fail_cnt`←0.
  - Otherwise, if `timer`==0 → failure: `fail_cnt`←`fail_cnt`+1.
    - If the new value equals MAX_FAILS → LOCKOUT, `timer`←LOCKOUT−1.
    - Otherwise → IDLE.
  - Otherwise `timer`−1.
  - `start` is ignored.
- **OPEN**
  - `timer`==0 → IDLE. Otherwise `timer`−1.
  - `start` and `match` are ignored.
- **LOCKOUT**
  - `timer`==0 → IDLE, `fail_cnt`←0. Otherwise `timer`−1.
  - `fail_cnt` holds MAX_FAILS for the whole lockout.
  - `start` and `match` are ignored; a dropped `start` is not queued.
- Outputs are Moore, decoded from registered state:
  - `unlock` = (state==OPEN).
  - `busy` = (state≠IDLE).
  - `alarm` = (state==LOCKOUT) when the macro is enabled.
- Simultaneous events:
  - `match` in the last ARMED cycle (`timer`==0): the match wins and no failure is counted.
  - `start` and `match` in the same IDLE cycle: → ARMED; that `match` is not credited.
- `fail_cnt` clears only on a successful match, on lockout exit, or on reset. Failures separated by IDLE periods still accumulate.

## Timing
- Reset: state IDLE; `timer`=0, `fail_cnt`=0, `unlock`=0, `busy`=0, `alarm`=0. Reset is checked before every other condition, so asserting `rst` mid-ARMED/OPEN/LOCKOUT forces IDLE and all-zero outputs on the next edge.
- `start` sampled at edge n → `busy`=1 from n+1.
- No match: ARMED lasts exactly WINDOW cycles, and `fail_cnt` updates on the edge that leaves ARMED.
- `match` sampled at edge k in ARMED → `unlock`=1 for exactly HOLD cycles starting at k+1.
- LOCKOUT lasts exactly LOCKOUT cycles, then IDLE with `fail_cnt`=0.
- Back-to-back: `start` in the first IDLE cycle after OPEN or LOCKOUT is accepted. IDLE is one cycle minimum.

## Configuration
- `LOCK_ALARM_EN` defined: `alarm` is driven high for every cycle in LOCKOUT.
- `LOCK_ALARM_EN` undefined: `alarm` is tied to 0 and no alarm logic is built. Lockout timing, `busy` and `fail_cnt` are unchanged.

## Structure
- Shared package `lock_pkg`:
  - `lock_state_t` enum with encodings IDLE=2'b00, ARMED=2'b01, OPEN=2'b10, LOCKOUT=2'b11.
  - Default parameter constants.
- Sub-module `lock_timer`: loadable down-counter.
  - Inputs: `load`, `load_val`, `en`.
  - Output: `zero` flag.
  - Instantiated once and shared by all three timed states.

## Test plan
- Reset, `start`, `match` on the 3rd ARMED cycle → `unlock`=1 for exactly 8 cycles, then IDLE, `busy`=0, `fail_cnt`=0.
- `start` with no `match` → IDLE after exactly 16 ARMED cycles, `fail_cnt`=1, `unlock` never high.
- Three windows time out in a row → LOCKOUT for 32 cycles:
  - `alarm`=1 and `fail_cnt`=3 throughout.
  - A `start` during lockout is ignored.
  - At exit, `fail_cnt`=0.
- `match` coincident with the 16th (last) ARMED cycle → OPEN, `unlock` for 8 cycles, `fail_cnt` unchanged by a failure.
- `rst` pulsed on the 4th OPEN cycle → next cycle `unlock`=0, `busy`=0, `fail_cnt`=0; a following `start` opens a fresh 16-cycle window.
- Build without `LOCK_ALARM_EN`, repeat the lockout scenario → `alarm` stays 0, lockout still lasts 32 cycles.
